// File: rtl/sort_arbiter_pkg.sv
// Shared types and helpers for the sorter-front arbiter.
// No logic; provides the FSM state encoding and width/length helpers.
// Ports: none (package).
package sort_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PASS     = 2'd1,
        DROP     = 2'd2,
        WAIT_RES = 2'd3
    } state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Longest packet the sorter can hold.
    function automatic int maxlen(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/sort_arbiter_if.sv
// Bundle of requester-side and sorter-side signals around the arbiter.
// Combinational wires only; no latency of its own.
// Backpressure: none here; granting is gated by sort_busy_i inside the arbiter.
// master = arbiter view, slave = requesters/sorter view.
interface sort_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8
);
    localparam int IDW = sort_arb_pkg::idw(NREQ);

    // requester side
    logic [NREQ-1:0]        req_i;
    logic [NREQ*DWIDTH-1:0] data_i;
    logic [NREQ-1:0]        sop_i;
    logic [NREQ-1:0]        eop_i;
    logic [NREQ-1:0]        val_i;
    logic [NREQ-1:0]        gnt_o;
    logic                   trunc_o;

    // towards the sorter input
    logic [DWIDTH-1:0]      sort_data_o;
    logic                   sort_sop_o;
    logic                   sort_eop_o;
    logic                   sort_val_o;

    // back from the sorter
    logic                   sort_busy_i;
    logic [DWIDTH-1:0]      sort_data_i;
    logic                   sort_sop_i;
    logic                   sort_eop_i;
    logic                   sort_val_i;

    // tagged result stream
    logic [DWIDTH-1:0]      res_data_o;
    logic                   res_sop_o;
    logic                   res_eop_o;
    logic                   res_val_o;
    logic [IDW-1:0]         res_id_o;

    modport master (
        input  req_i, data_i, sop_i, eop_i, val_i,
        input  sort_busy_i, sort_data_i, sort_sop_i, sort_eop_i, sort_val_i,
        output gnt_o, trunc_o,
        output sort_data_o, sort_sop_o, sort_eop_o, sort_val_o,
        output res_data_o, res_sop_o, res_eop_o, res_val_o, res_id_o
    );

    modport slave (
        output req_i, data_i, sop_i, eop_i, val_i,
        output sort_busy_i, sort_data_i, sort_sop_i, sort_eop_i, sort_val_i,
        input  gnt_o, trunc_o,
        input  sort_data_o, sort_sop_o, sort_eop_o, sort_val_o,
        input  res_data_o, res_sop_o, res_eop_o, res_val_o, res_id_o
    );

endinterface

// File: rtl/sort_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after 'last', wrapping around.
// Latency: purely combinational.
// Backpressure: none; gnt is all-zero when no request is pending.
// Ports: req (pending requests), last (previous winner) -> gnt (one-hot), idx (winner index).
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IDW:0]   w_sh;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_off;
    logic           w_found;

    always_comb begin
        // Rotating the doubled vector right by last+1 puts the highest-priority
        // requester at bit 0, so a plain lowest-set-bit search does the job.
        w_dbl   = {req, req};
        w_sh    = {1'b0, last} + {{IDW{1'b0}}, 1'b1};
        w_rot   = N'(w_dbl >> w_sh);
        w_found = 1'b0;
        w_off   = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = IDW'(i);
            end
        end
        // last+1+offset is below 2N, so one conditional subtract is a full modulo.
        w_sum = w_sh + {1'b0, w_off};
        if (w_sum >= (IDW+1)'(N)) begin
            w_sum = w_sum - (IDW+1)'(N);
        end
        idx = w_sum[IDW-1:0];
        gnt = '0;
        if (w_found) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sort_arbiter.sv
// Shares one sorter between NREQ sources: round-robin grant, forward owner packet, tag results.
// Latency: req->gnt 1 cycle, owner word->sort_* 1 cycle, sorter output->res_* 1 cycle.
// Backpressure: no new grant while sort_busy_i=1 or until the previous sorted result's eop.
// Ports: clk_i, srst_i (sync, active-low); bus.master carries requester, sorter and result signals.
module sort_arbiter
    import sort_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 3
) (
    input  logic           clk_i,
    input  logic           srst_i,
    sort_arbiter_if.master bus
);

    localparam int IDW    = idw(NREQ);
    localparam int MAXLEN = maxlen(AWIDTH);
    localparam logic [AWIDTH-1:0] CNT_LAST = AWIDTH'(MAXLEN - 1);
    // Reset 'last' to the top index so requester 0 is first in line.
    localparam logic [IDW-1:0]    LAST_RST = IDW'(NREQ - 1);

    state_t              r_state, w_state_nxt;
    logic [NREQ-1:0]     r_gnt, w_gnt_nxt;
    logic [IDW-1:0]      r_owner, w_owner_nxt;
    logic [IDW-1:0]      r_last, w_last_nxt;
    logic [AWIDTH-1:0]   r_cnt, w_cnt_nxt;
    logic                r_trunc, w_trunc_nxt;
    logic [DWIDTH-1:0]   r_sort_data, w_sort_data_nxt;
    logic                r_sort_sop, w_sort_sop_nxt;
    logic                r_sort_eop, w_sort_eop_nxt;
    logic                r_sort_val, w_sort_val_nxt;

    logic [DWIDTH-1:0]   r_res_data;
    logic                r_res_sop, r_res_eop, r_res_val;
    logic [IDW-1:0]      r_res_id;

    logic [NREQ-1:0]     w_pick_gnt;
    logic [IDW-1:0]      w_pick_idx;
    logic                w_own_val, w_own_sop, w_own_eop;
    logic [DWIDTH-1:0]   w_own_data;

    rr_pick #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_pick (
        .req  (bus.req_i),
        .last (r_last),
        .gnt  (w_pick_gnt),
        .idx  (w_pick_idx)
    );

    // Only the owner's lane is ever looked at; all other lanes are ignored.
    assign w_own_val  = bus.val_i[r_owner];
    assign w_own_sop  = bus.sop_i[r_owner];
    assign w_own_eop  = bus.eop_i[r_owner];
    assign w_own_data = bus.data_i[r_owner*DWIDTH +: DWIDTH];

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_owner_nxt     = r_owner;
        w_last_nxt      = r_last;
        w_cnt_nxt       = r_cnt;
        w_trunc_nxt     = 1'b0;
        w_sort_data_nxt = r_sort_data;
        w_sort_sop_nxt  = 1'b0;
        w_sort_eop_nxt  = 1'b0;
        w_sort_val_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if ((|bus.req_i) && !bus.sort_busy_i) begin
                    w_gnt_nxt   = w_pick_gnt;
                    w_owner_nxt = w_pick_idx;
                    w_last_nxt  = w_pick_idx;
                    w_cnt_nxt   = '0;
                    w_state_nxt = PASS;
                end
            end
            PASS: begin
                if (w_own_val) begin
                    w_sort_data_nxt = w_own_data;
                    w_sort_sop_nxt  = w_own_sop;
                    w_sort_val_nxt  = 1'b1;
                    w_cnt_nxt       = r_cnt + AWIDTH'(1);
                    if (w_own_eop) begin
                        w_sort_eop_nxt = 1'b1;
                        w_gnt_nxt      = '0;
                        w_state_nxt    = WAIT_RES;
                    end else if (r_cnt == CNT_LAST) begin
                        // Sorter is full: close its packet here and swallow the rest.
                        w_sort_eop_nxt = 1'b1;
                        w_trunc_nxt    = 1'b1;
                        w_state_nxt    = DROP;
                    end
                end
            end
            DROP: begin
                if (w_own_val && w_own_eop) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (bus.sort_val_i && bus.sort_eop_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_owner     <= '0;
            r_last      <= LAST_RST;
            r_cnt       <= '0;
            r_trunc     <= 1'b0;
            r_sort_data <= '0;
            r_sort_sop  <= 1'b0;
            r_sort_eop  <= 1'b0;
            r_sort_val  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_cnt       <= w_cnt_nxt;
            r_trunc     <= w_trunc_nxt;
            r_sort_data <= w_sort_data_nxt;
            r_sort_sop  <= w_sort_sop_nxt;
            r_sort_eop  <= w_sort_eop_nxt;
            r_sort_val  <= w_sort_val_nxt;
        end
    end

    // Result path runs in every state. The owner only changes on a new grant,
    // which cannot happen before the result eop, so the tag stays correct.
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            r_res_data <= '0;
            r_res_sop  <= 1'b0;
            r_res_eop  <= 1'b0;
            r_res_val  <= 1'b0;
            r_res_id   <= '0;
        end else begin
            r_res_data <= bus.sort_data_i;
            r_res_sop  <= bus.sort_sop_i;
            r_res_eop  <= bus.sort_eop_i;
            r_res_val  <= bus.sort_val_i;
            r_res_id   <= r_owner;
        end
    end

    assign bus.gnt_o       = r_gnt;
    assign bus.trunc_o     = r_trunc;
    assign bus.sort_data_o = r_sort_data;
    assign bus.sort_sop_o  = r_sort_sop;
    assign bus.sort_eop_o  = r_sort_eop;
    assign bus.sort_val_o  = r_sort_val;
    assign bus.res_data_o  = r_res_data;
    assign bus.res_sop_o   = r_res_sop;
    assign bus.res_eop_o   = r_res_eop;
    assign bus.res_val_o   = r_res_val;
    assign bus.res_id_o    = r_res_id;

endmodule
